mvu_job_dispatcher: RTL and testbench
=====================================

Name: mvu_job_dispatcher

Overview:
- Sits between the per-hart barrel CSR files and a single shared MVU.
- Collects per-hart mvu_start pulses and snapshots that hart's MVU job descriptor from the packed CSR buses.
- Issues one job at a time to the MVU with a valid/ready handshake, using round-robin among harts.
- Returns a one-cycle completion pulse on the hart's mvu_irq bit, which feeds the CSR files' mvu_irq input. A watchdog aborts hung jobs.

Parameters:
- NUM_HARTS, 8: number of barrel harts; power of two, ≥2.
- TIMEOUT_CYCLES, 65535: maximum cycles in BUSY before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- mvu_start  in  NUM_HARTS  per-hart start pulse from the CSR files
- csr_mvu_wbaseaddr  in  32*NUM_HARTS  packed per-hart field; hart h is in [h*32 +: 32]
- csr_mvu_ibaseaddr  in  32*NUM_HARTS  same packing
- csr_mvu_obaseaddr  in  32*NUM_HARTS  same packing
- csr_mvu_precision  in  32*NUM_HARTS  same packing
- csr_mvu_quant  in  32*NUM_HARTS  same packing
- csr_mvu_command  in  32*NUM_HARTS  same packing
- job_valid  out  1  descriptor valid toward the MVU
- job_ready  in  1  MVU accepts the descriptor
- job_hart  out  HART_CNT_WIDTH  hart owning the issued job
- job_desc  out  mvu_job_desc_t  registered descriptor snapshot
- mvu_done  in  1  one-cycle completion pulse from the MVU
- mvu_abort  out  1  one-cycle pulse asking the MVU to flush on timeout
- mvu_irq  out  NUM_HARTS  one-cycle completion pulse per hart
- job_err  out  NUM_HARTS  sticky per-hart error (overrun or timeout)
- err_clr  in  NUM_HARTS  clears the matching job_err bits

Behaviour:
- Reset:
  - pending=0, job_valid=0, job_hart=0, job_desc=0, mvu_abort=0, mvu_irq=0, job_err=0.
  - rr_ptr=0, watchdog counter=0, state=IDLE.
  - Reset mid-job drops all pending and in-flight work; no irq is emitted.
- Request capture:
  - mvu_start[h]=1 in cycle t sets pending[h] at t+1.
  - In the same cycle t, the six fields of hart h are registered into a per-hart descriptor slot, giving a snapshot at start time.
  - Overrun: start[h] while pending[h]=1, or while hart h owns a job in ISSUE/BUSY → request ignored, slot unchanged, job_err[h] set.
  - A start in the IRQ cycle of the same hart is accepted.
- Arbitration:
  - Round-robin over pending, beginning at rr_ptr.
  - The winner's pending bit is cleared on transition to ISSUE.
  - rr_ptr ← winner+1, mod NUM_HARTS.
- FSM states:
  - IDLE: if any pending → ISSUE, latching job_hart and job_desc from the winner's slot; job_valid=1 from the next cycle.
  - ISSUE: hold job_valid, job_hart and job_desc stable until job_ready=1. On the handshake → BUSY and job_valid=0 the next cycle.
  - BUSY:
    - Counter increments each cycle.
    - mvu_done=1 → IRQ.
    - If TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES without done → pulse mvu_abort, set job_err[job_hart], go to IRQ.
    - Done arriving in the same cycle as the timeout counts as done: no error.
  - IRQ: mvu_irq[job_hart]=1 for exactly one cycle, counter cleared → IDLE.
- Timing:
  - Minimum start-to-job_valid latency is 2 cycles (start → pending → IDLE picks → valid).
  - Back-to-back jobs have one IDLE cycle between the IRQ cycle and the next ISSUE.
- mvu_done outside BUSY is ignored. job_ready outside ISSUE is ignored.
- err_clr[h] clears job_err[h]; a set event in the same cycle wins.
- Counter width is clog2(TIMEOUT_CYCLES+1) and saturates.

Decomposition:
- pito_pkg additions:
  - mvu_job_desc_t: packed struct {wbaseaddr, ibaseaddr, obaseaddr, precision, quant, command}, 32 bits each.
  - dispatcher state enum {IDLE, ISSUE, BUSY, IRQ}.
  - HART_CNT_WIDTH, which already exists in pito_pkg.
- One sub-module, rr_arbiter (parameter N): inputs req[N] and ptr; outputs grant_valid and grant_idx; combinational priority rotate.

Test Plan:
1. Single job:
   - Stimulus: start[3] with wbaseaddr[3]=0x100; job_ready held 1; mvu_done 5 cycles after the handshake.
   - Required: job_valid 2 cycles after start, job_hart=3, job_desc.wbaseaddr=0x100; mvu_irq=0x08 for exactly one cycle; job_err=0.
2. Simultaneous starts:
   - Stimulus: start=0xFF in one cycle with rr_ptr=0; each job completes.
   - Required: issue order is harts 0,1,…,7; each irq bit pulses once.
3. Backpressure and snapshot:
   - Stimulus: job_ready=0 for 10 cycles; the CSR field of hart 3 is changed after its start.
   - Required: job_valid, job_hart and job_desc stay stable for 10 cycles; job_desc keeps the start-time snapshot.
4. Overrun:
   - Stimulus: start[2] twice while job 2 is BUSY.
   - Required: job_err[2]=1; only one irq; the second request is dropped; err_clr[2] clears job_err[2] the next cycle.
5. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16; mvu_done never asserted.
   - Required: mvu_abort pulses 16 cycles after entering BUSY; job_err[h]=1; mvu_irq[h] pulses; FSM returns to IDLE.
6. Reset mid-BUSY:
   - Stimulus: rst_n low while harts 1 and 5 are pending.
   - Required: all outputs 0 immediately; after release, no job issues until a new start.

Source files
------------

// File: rtl/mvu_job_dispatcher_pkg.sv
// Shared types for the MVU job dispatcher.
//   mvu_job_desc_t : six 32-bit job fields snapshotted from a hart's CSRs
//   disp_state_e   : dispatcher FSM states
//   HART_CNT_WIDTH : hart index width for the default barrel (8 harts)
package mvu_job_dispatcher_pkg;

    localparam int HART_CNT_WIDTH = 3;

    typedef struct packed {
        logic [31:0] wbaseaddr;
        logic [31:0] ibaseaddr;
        logic [31:0] obaseaddr;
        logic [31:0] precision;
        logic [31:0] quant;
        logic [31:0] command;
    } mvu_job_desc_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_IRQ   = 2'd3
    } disp_state_e;

endpackage

// File: rtl/mvu_job_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector
//   ptr         : index with highest priority this cycle
//   grant_valid : some request is set
//   grant_idx   : first set request at or after ptr (wrapping)
module mvu_job_dispatcher_rr_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] w_idx;

    // N is a power of two, so ptr+i wraps naturally in IW bits.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_idx       = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = ptr + IW'(i);
            if (!grant_valid && req[w_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/mvu_job_dispatcher.sv
// Dispatches per-hart MVU jobs to one shared MVU.
//   mvu_start / csr_mvu_*  : per-hart start pulse and packed CSR fields (hart h at [h*32 +: 32])
//   job_valid/ready/hart/desc : descriptor handshake toward the MVU
//   mvu_done / mvu_abort   : completion pulse from MVU, flush pulse on watchdog timeout
//   mvu_irq                : one-cycle completion pulse to the owning hart
//   job_err / err_clr      : sticky per-hart overrun/timeout flags and their clear
module mvu_job_dispatcher
    import mvu_job_dispatcher_pkg::*;
#(
    parameter int NUM_HARTS      = 1 << HART_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_HARTS-1:0]          mvu_start,
    input  logic [32*NUM_HARTS-1:0]       csr_mvu_wbaseaddr,
    input  logic [32*NUM_HARTS-1:0]       csr_mvu_ibaseaddr,
    input  logic [32*NUM_HARTS-1:0]       csr_mvu_obaseaddr,
    input  logic [32*NUM_HARTS-1:0]       csr_mvu_precision,
    input  logic [32*NUM_HARTS-1:0]       csr_mvu_quant,
    input  logic [32*NUM_HARTS-1:0]       csr_mvu_command,
    output logic                          job_valid,
    input  logic                          job_ready,
    output logic [$clog2(NUM_HARTS)-1:0]  job_hart,
    output mvu_job_desc_t                 job_desc,
    input  logic                          mvu_done,
    output logic                          mvu_abort,
    output logic [NUM_HARTS-1:0]          mvu_irq,
    output logic [NUM_HARTS-1:0]          job_err,
    input  logic [NUM_HARTS-1:0]          err_clr
);
    localparam int HW = $clog2(NUM_HARTS);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO = CW'(TIMEOUT_CYCLES);

    disp_state_e          r_state, w_state_nxt;
    logic [NUM_HARTS-1:0] r_pending, r_err;
    logic [NUM_HARTS-1:0] w_owned, w_accept, w_overrun, w_take_oh, w_err_set;
    logic [HW-1:0]        r_rr_ptr, r_job_hart, w_grant_idx;
    logic                 w_grant_valid, w_take, w_timeout;
    logic [CW-1:0]        r_cnt;
    mvu_job_desc_t        r_job_desc;
    mvu_job_desc_t        r_slot [NUM_HARTS];

    mvu_job_dispatcher_rr_arbiter #(.N(NUM_HARTS)) u_arb (
        .req         (r_pending),
        .ptr         (r_rr_ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // A hart owns the MVU from ISSUE through BUSY; in IRQ it may start again.
    always_comb begin
        w_owned = '0;
        if (r_state == S_ISSUE || r_state == S_BUSY)
            w_owned[r_job_hart] = 1'b1;
    end

    assign w_overrun = mvu_start & (r_pending | w_owned);
    assign w_accept  = mvu_start & ~(r_pending | w_owned);

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: if (job_ready) w_state_nxt = S_BUSY;
            S_BUSY: begin
                // done wins over a coincident timeout
                if (mvu_done) begin
                    w_state_nxt = S_IRQ;
                end else if (TIMEOUT_CYCLES != 0 && r_cnt == TO) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IRQ;
                end
            end
            S_IRQ:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_take_oh = '0;
        if (w_take) w_take_oh[w_grant_idx] = 1'b1;
    end

    always_comb begin
        w_err_set = w_overrun;
        if (w_timeout) w_err_set[r_job_hart] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_err      <= '0;
            r_rr_ptr   <= '0;
            r_job_hart <= '0;
            r_job_desc <= '0;
            r_cnt      <= '0;
        end else begin
            r_pending <= (r_pending & ~w_take_oh) | w_accept;
            r_err     <= (r_err & ~err_clr) | w_err_set;
            if (w_take) begin
                r_job_hart <= w_grant_idx;
                r_job_desc <= r_slot[w_grant_idx];
                r_rr_ptr   <= w_grant_idx + HW'(1);
            end
            if (r_state == S_BUSY) begin
                if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
            end else if (r_state == S_IRQ) begin
                r_cnt <= '0;
            end
        end
    end

    // Per-hart descriptor slots: snapshot taken on an accepted start.
    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slot[h] <= '0;
            end else if (w_accept[h]) begin
                r_slot[h] <= '{wbaseaddr: csr_mvu_wbaseaddr[h*32 +: 32],
                               ibaseaddr: csr_mvu_ibaseaddr[h*32 +: 32],
                               obaseaddr: csr_mvu_obaseaddr[h*32 +: 32],
                               precision: csr_mvu_precision[h*32 +: 32],
                               quant:     csr_mvu_quant[h*32 +: 32],
                               command:   csr_mvu_command[h*32 +: 32]};
            end
        end
    end

    always_comb begin
        mvu_irq = '0;
        if (r_state == S_IRQ) mvu_irq[r_job_hart] = 1'b1;
    end

    assign job_valid = (r_state == S_ISSUE);
    assign job_hart  = r_job_hart;
    assign job_desc  = r_job_desc;
    assign mvu_abort = w_timeout;
    assign job_err   = r_err;

endmodule

// File: tb/tb_mvu_job_dispatcher.sv
module tb_mvu_job_dispatcher;
    import mvu_job_dispatcher_pkg::*;

    localparam int NH = 8;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NH-1:0]    mvu_start, err_clr, mvu_irq, job_err;
    logic [32*NH-1:0] wb, ib, ob, pr, qu, cm;
    logic             job_ready, mvu_done, job_valid, mvu_abort;
    logic [2:0]       job_hart;
    mvu_job_desc_t    job_desc;

    int n_vec = 0;
    int n_err = 0;
    int irq_cnt [NH];
    bit mon_clr = 1'b0;

    always #5 clk = ~clk;

    mvu_job_dispatcher #(.NUM_HARTS(NH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mvu_start(mvu_start),
        .csr_mvu_wbaseaddr(wb), .csr_mvu_ibaseaddr(ib), .csr_mvu_obaseaddr(ob),
        .csr_mvu_precision(pr), .csr_mvu_quant(qu), .csr_mvu_command(cm),
        .job_valid(job_valid), .job_ready(job_ready), .job_hart(job_hart),
        .job_desc(job_desc), .mvu_done(mvu_done), .mvu_abort(mvu_abort),
        .mvu_irq(mvu_irq), .job_err(job_err), .err_clr(err_clr)
    );

    always @(negedge clk) begin
        for (int h = 0; h < NH; h++) begin
            if (mon_clr)         irq_cnt[h] <= 0;
            else if (mvu_irq[h]) irq_cnt[h] <= irq_cnt[h] + 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_fields(input int h, input logic [31:0] b);
        wb[h*32 +: 32] = b;
        ib[h*32 +: 32] = b + 32'h10;
        ob[h*32 +: 32] = b + 32'h20;
        pr[h*32 +: 32] = b + 32'h30;
        qu[h*32 +: 32] = b + 32'h40;
        cm[h*32 +: 32] = b + 32'h50;
    endtask

    function automatic mvu_job_desc_t mk(input logic [31:0] b);
        mk = '{b, b + 32'h10, b + 32'h20, b + 32'h30, b + 32'h40, b + 32'h50};
    endfunction

    task automatic pulse_start(input logic [NH-1:0] m);
        mvu_start = m;
        step();
        mvu_start = '0;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        smp();
        step();
        mon_clr = 1'b0;
    endtask

    task automatic wait_valid(input int lim);
        int k = 0;
        smp();
        while (!job_valid && k < lim) begin
            step();
            smp();
            k++;
        end
        chk("wait_valid", 256'(job_valid), 256'(1));
    endtask

    // Issue with job_ready high; done after dly extra BUSY cycles.
    task automatic run_job(input int h, input int dly);
        wait_valid(20);
        chk("hart", 256'(job_hart), 256'(h));
        step();
        repeat (dly) step();
        mvu_done = 1'b1;
        step();
        mvu_done = 1'b0;
        smp();
        chk("irq", 256'(mvu_irq), 256'(1) << h);
        step();
        smp();
        chk("irq_off", 256'(mvu_irq), 256'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_mon();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        mvu_start = '0; err_clr = '0; job_ready = 1'b0; mvu_done = 1'b0;
        wb = '0; ib = '0; ob = '0; pr = '0; qu = '0; cm = '0;

        // reset state
        smp();
        chk("rst_outs", {job_valid, job_hart, job_desc, mvu_abort, mvu_irq, job_err}, '0);
        do_reset();

        // 1: single job on hart 3, done 5 cycles after handshake
        set_fields(3, 32'h100);
        job_ready = 1'b1;
        pulse_start(8'h08);
        smp(); chk("t1_lat1", 256'(job_valid), 256'(0));
        step(); smp();
        chk("t1_valid", 256'(job_valid), 256'(1));
        chk("t1_hart", 256'(job_hart), 256'(3));
        chk("t1_wbase", 256'(job_desc.wbaseaddr), 256'(32'h100));
        chk("t1_desc", 256'(job_desc), 256'(mk(32'h100)));
        step(); smp();
        chk("t1_valid_drop", 256'(job_valid), 256'(0));
        repeat (4) step();
        mvu_done = 1'b1;
        smp(); chk("t1_no_early_irq", 256'(mvu_irq), 256'(0));
        step(); mvu_done = 1'b0;
        smp();
        chk("t1_irq", 256'(mvu_irq), 256'(8'h08));
        chk("t1_err", 256'(job_err), 256'(0));
        step(); smp();
        chk("t1_irq_off", 256'(mvu_irq), 256'(0));
        step();
        chk("t1_irq_once", 256'(irq_cnt[3]), 256'(1));

        // 2: all harts start together from rr_ptr=0
        do_reset();
        pulse_start(8'hFF);
        for (int i = 0; i < NH; i++) run_job(i, 1);
        step();
        for (int h = 0; h < NH; h++) chk("t2_irq_once", 256'(irq_cnt[h]), 256'(1));

        // 3: backpressure, CSR changed after start
        job_ready = 1'b0;
        set_fields(3, 32'h333);
        pulse_start(8'h08);
        set_fields(3, 32'hDEAD0000);
        wait_valid(5);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin step(); smp(); end
            chk("t3_hold", {job_valid, job_hart, job_desc}, {1'b1, 3'd3, mk(32'h333)});
        end
        step();
        job_ready = 1'b1;
        run_job(3, 0);

        // 4: overrun on hart 2 while BUSY
        clr_mon();
        set_fields(2, 32'h200);
        pulse_start(8'h04);
        wait_valid(5);
        chk("t4_hart", 256'(job_hart), 256'(2));
        step();
        mvu_start = 8'h04;
        step(); smp();
        chk("t4_err_set", 256'(job_err), 256'(8'h04));
        step();
        mvu_start = '0;
        mvu_done = 1'b1;
        step(); mvu_done = 1'b0;
        smp(); chk("t4_irq", 256'(mvu_irq), 256'(8'h04));
        for (int i = 0; i < 6; i++) begin
            step(); smp();
            chk("t4_dropped", 256'(job_valid), 256'(0));
        end
        chk("t4_irq_once", 256'(irq_cnt[2]), 256'(1));
        err_clr = 8'h04;
        chk("t4_err_hold", 256'(job_err), 256'(8'h04));
        step(); err_clr = '0;
        smp(); chk("t4_err_clr", 256'(job_err), 256'(0));

        // 5: watchdog timeout on hart 6
        set_fields(6, 32'h600);
        pulse_start(8'h40);
        wait_valid(5);
        chk("t5_hart", 256'(job_hart), 256'(6));
        step();
        begin
            bit early = 1'b0;
            for (int k = 0; k < TO; k++) begin
                smp();
                if (mvu_abort || mvu_irq != 0) early = 1'b1;
                step();
            end
            chk("t5_no_early_abort", 256'(early), 256'(0));
        end
        smp();
        chk("t5_abort", 256'(mvu_abort), 256'(1));
        chk("t5_err_not_yet", 256'(job_err), 256'(0));
        step(); smp();
        chk("t5_abort_pulse", 256'(mvu_abort), 256'(0));
        chk("t5_irq", 256'(mvu_irq), 256'(8'h40));
        chk("t5_err", 256'(job_err), 256'(8'h40));
        step(); smp();
        chk("t5_idle", 256'({job_valid, mvu_irq}), 256'(0));

        // 5b: done in the timeout cycle counts as done
        set_fields(7, 32'h700);
        pulse_start(8'h80);
        wait_valid(5);
        step();
        repeat (TO) step();
        mvu_done = 1'b1;
        smp(); chk("t5b_no_abort", 256'(mvu_abort), 256'(0));
        step(); mvu_done = 1'b0;
        smp();
        chk("t5b_irq", 256'(mvu_irq), 256'(8'h80));
        chk("t5b_no_err", 256'(job_err), 256'(8'h40));

        // 6: reset with harts 1 and 5 pending behind a BUSY job
        err_clr = 8'hFF;
        step(); err_clr = '0;
        pulse_start(8'h01);
        wait_valid(5);
        step();
        pulse_start(8'h23);
        smp(); chk("t6_pre_err", 256'(job_err), 256'(8'h01));
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", {job_valid, job_hart, job_desc, mvu_abort, mvu_irq, job_err}, '0);
        step(); step();
        rst_n = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                smp();
                if (job_valid || mvu_irq != 0) seen = 1'b1;
                step();
            end
            chk("t6_no_stale_job", 256'(seen), 256'(0));
        end
        set_fields(4, 32'h400);
        pulse_start(8'h10);
        smp(); chk("t6_lat1", 256'(job_valid), 256'(0));
        step(); smp();
        chk("t6_valid", 256'(job_valid), 256'(1));
        chk("t6_hart", 256'(job_hart), 256'(4));
        chk("t6_desc", 256'(job_desc), 256'(mk(32'h400)));
        step();
        mvu_done = 1'b1;
        step(); mvu_done = 1'b0;
        smp(); chk("t6_irq", 256'(mvu_irq), 256'(8'h10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
